// File: rtl/uncached_agent_pkg.sv
// Shared types for the uncached request agent: request payload, FSM states and size codes.
package uncached_agent_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef struct packed {
      logic              wr;
      logic [1:0]        size;
      logic [STRB_W-1:0] wstrb;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } uc_req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT_R = 2'd2,
      WAIT_B = 2'd3
   } uc_state_t;

endpackage

// File: rtl/uc_req_fifo.sv
// In-order request queue for the uncached agent; head is the oldest accepted request.
module uc_req_fifo
   import uncached_agent_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  uc_req_t                      din,
   output uc_req_t                      head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   uc_req_t       mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uncached_agent.sv
// Uncached request responder: queues accepted requests and replays each as one bus beat.
// Define UNCACHED_POSTED_WRITE_EN to retire stores at bus grant (posted writes).
module uncached_agent
   import uncached_agent_pkg::*;
#(
   parameter int unsigned QDEPTH = 2,
   parameter int unsigned MAX_PW = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [DATA_W-1:0] rdata,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [STRB_W-1:0] bus_wstrb,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_bvalid
);

   localparam int unsigned CW = $clog2(QDEPTH + 1);

   uc_state_t     state;
   uc_req_t       in_req;
   uc_req_t       head;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          issue_ok;
   logic          grant;
   logic          more_after_pop;

   assign in_req = '{wr: wr, size: size, wstrb: wstrb, addr: addr, wdata: wdata};

   assign addr_ok        = !full;
   assign push           = req && !full;
   assign grant          = bus_req && bus_gnt;
   assign more_after_pop = (count > CW'(1)) || push;

   uc_req_fifo #(
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (in_req),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Bus fields come straight from the queue head, which only moves on a pop.
   assign bus_req   = (state == ISSUE) && issue_ok;
   assign bus_wr    = head.wr;
   assign bus_size  = head.size;
   assign bus_addr  = head.addr;
   assign bus_wstrb = head.wstrb;
   assign bus_wdata = head.wdata;

`ifdef UNCACHED_POSTED_WRITE_EN
   localparam int unsigned PW = $clog2(MAX_PW + 1);

   logic [PW-1:0] pw_cnt;
   logic          pw_inc;
   logic          pw_dec;

   assign pw_inc   = grant && head.wr;
   assign pw_dec   = bus_bvalid && (pw_cnt != '0);
   // Loads wait for all posted stores to drain; stores wait for a free slot.
   assign issue_ok = head.wr ? (pw_cnt != PW'(MAX_PW)) : (pw_cnt == '0);
   assign pop      = ((state == WAIT_R) && bus_rvalid) || pw_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         pw_cnt <= '0;
      end else begin
         case ({pw_inc, pw_dec})
            2'b10:   pw_cnt <= pw_cnt + PW'(1);
            2'b01:   pw_cnt <= pw_cnt - PW'(1);
            default: ;
         endcase
      end
   end
`else
   assign issue_ok = 1'b1;
   assign pop      = ((state == WAIT_R) && bus_rvalid) || ((state == WAIT_B) && bus_bvalid);
`endif

   // Request sequencer; a push in the same cycle counts toward a non-empty queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         data_ok <= 1'b0;
         rdata   <= '0;
      end else begin
         data_ok <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty || push) state <= ISSUE;
            end
            ISSUE: begin
               if (grant) begin
                  if (head.wr) begin
`ifdef UNCACHED_POSTED_WRITE_EN
                     data_ok <= 1'b1;
                     rdata   <= '0;
                     state   <= more_after_pop ? ISSUE : IDLE;
`else
                     state   <= WAIT_B;
`endif
                  end else begin
                     state <= WAIT_R;
                  end
               end
            end
            WAIT_R: begin
               if (bus_rvalid) begin
                  data_ok <= 1'b1;
                  rdata   <= bus_rdata;
                  state   <= more_after_pop ? ISSUE : IDLE;
               end
            end
            WAIT_B: begin
               if (bus_bvalid) begin
                  data_ok <= 1'b1;
                  rdata   <= '0;
                  state   <= more_after_pop ? ISSUE : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uncached_agent.md
Name: uncached_agent

Overview:
- Responder end of the cache-side request interface that the MMU drives: `req`/`addr_ok`/`data_ok` handshake with `wr`, `size`, `wstrb`, `addr`, `wdata`, `rdata`.
- Serves uncached (SUC) accesses from either the fetch or the data port.
- Buffers accepted requests in a small in-order queue and replays each one as a single-beat transaction on the memory-bus arbiter port.
- Returns one `data_ok` per accepted request, in acceptance order.

Parameters:
- QDEPTH, 2, number of accepted-but-not-retired requests (power of 2, ≥1).
- MAX_PW, 4, maximum posted writes awaiting `bus_bvalid` (used only with UNCACHED_POSTED_WRITE_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  1  request valid
- wr  in  1  1 = store
- size  in  2  0 = byte, 1 = half, 2 = word
- wstrb  in  4  byte enables (stores)
- addr  in  32  physical address
- wdata  in  32  store data
- addr_ok  out  1  request accepted this cycle when `req` is also high
- data_ok  out  1  one-cycle completion pulse
- rdata  out  32  load data, valid with `data_ok`
- bus_req  out  1  bus transaction valid
- bus_wr  out  1  bus store
- bus_size  out  2  copy of `size`
- bus_addr  out  32  copy of `addr`
- bus_wstrb  out  4  copy of `wstrb`
- bus_wdata  out  32  copy of `wdata`
- bus_gnt  in  1  bus accepted the request
- bus_rvalid  in  1  read data return
- bus_rdata  in  32  read data
- bus_bvalid  in  1  write response

Behaviour:
- Clocking: single clock `clk`; `reset` is synchronous and active-high. All state is cleared on the `clk` edge where `reset` = 1.
- Reset values: `data_ok` = 0, `rdata` = 0, `bus_req` = 0, queue empty, FSM in IDLE, posted counter = 0.
- `addr_ok` = !full. It is combinational from registered state only and does not depend on `req`. Acceptance = `req && addr_ok`; the fields are pushed into the queue tail.
- No same-cycle push bypass when the queue is full, even if a pop occurs in that cycle.
- FSM:
  - IDLE: go to ISSUE when the queue is non-empty.
  - ISSUE: `bus_req` = 1; the `bus_*` fields are driven from the queue head and held stable until `bus_gnt`. On `bus_gnt`, go to WAIT_R if the head is a load, WAIT_B if it is a store.
  - WAIT_R: on `bus_rvalid`, pop the head, register `rdata` = `bus_rdata`, and pulse `data_ok` in the next cycle.
  - WAIT_B: on `bus_bvalid`, pop the head, register `rdata` = 0, and pulse `data_ok` in the next cycle.
  - After a pop: go to ISSUE if the queue is still non-empty (the entry just pushed counts), else IDLE.
- Minimum load latency: accept at cycle 0 → `bus_req` at cycle 1 (`bus_gnt` the same cycle) → `bus_rvalid` at cycle 2 → `data_ok` at cycle 3.
- `bus_rvalid` or `bus_bvalid` outside its matching WAIT state is ignored.
- `data_ok` is high for exactly one cycle per request; responses are never reordered.
- `rdata` holds its value between pulses.
- No alignment checking or data shifting; `size`, `addr` and `wstrb` pass through unchanged.
- Reset mid-transaction: any in-flight bus transaction is abandoned. The bus side shares this reset, so no late response is expected.

Optional Feature:
- Macro: UNCACHED_POSTED_WRITE_EN.
- Defined:
  - A store retires at `bus_gnt`: the head is popped and `data_ok` pulses the next cycle. WAIT_B is skipped and the posted counter is incremented.
  - `bus_bvalid` decrements the counter. Simultaneous increment and decrement leaves it unchanged.
  - A head load stays in ISSUE with `bus_req` = 0 while counter ≠ 0.
  - A head store stays in ISSUE with `bus_req` = 0 while counter = MAX_PW.
- Undefined: the counter logic is absent and stores wait for `bus_bvalid` as described above.

Decomposition:
- Shared package:
  - `uc_req_t` struct (`wr`, `size`, `wstrb`, `addr`, `wdata`).
  - `uc_state_t` enum (IDLE, ISSUE, WAIT_R, WAIT_B).
  - Size encoding constants.
- Sub-module: `uc_req_fifo`. It is a parameterised synchronous FIFO of `uc_req_t` with push, pop, full, empty and a head output. Same-cycle push and pop are legal when the FIFO is non-empty and not full.

Test Plan:
- Single load of word 0x1FE0_0010: `bus_gnt` granted immediately, `bus_rvalid` with 0xDEAD_BEEF one cycle later → `data_ok` at cycle 3, `rdata` = 0xDEAD_BEEF, exactly one `bus_req` handshake.
- Store to 0xBFAF_F000, `wstrb` = 0x3, data 0x1234: `bus_bvalid` delayed 5 cycles → `data_ok` only after `bus_bvalid`, `rdata` = 0, `bus_wstrb` = 0x3.
- `req` held high for 4 loads, QDEPTH = 2, `bus_gnt` stalled 3 cycles → `addr_ok` drops after 2 acceptances. The 4 `data_ok` pulses return in issue order with matching data.
- Load, store, load back-to-back with random `bus_gnt`/`bus_rvalid`/`bus_bvalid` delays of 0–4 cycles → 3 in-order `data_ok` pulses; bus fields are stable whenever `bus_req && !bus_gnt`.
- `reset` asserted in WAIT_R → the next cycle shows `bus_req` = 0, `addr_ok` = 1 and no `data_ok`; a subsequent load completes normally.
- With UNCACHED_POSTED_WRITE_EN, store then load, `bus_bvalid` 6 cycles after grant → the store's `data_ok` appears the cycle after `bus_gnt`. The load's `bus_req` is not asserted until the cycle after `bus_bvalid`.
